keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 10000, meaning clock cycles each column is driven (minimum 2).
REQ-002 SHALL provide parameter DEBOUNCE, default 4, meaning consecutive identical scan frames required to accept a press or a release (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port row, input, 4 bits: keypad row lines, active-low, externally pulled up.
REQ-006 SHALL have port col, output, 4 bits: keypad column drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port key, output, 5 bits: debounced key code (`KEY_0..`KEY_9 = 5'h00..5'h09, `KEY_A..`KEY_F = 5'h0A..5'h0F, `KEY_NONE = 5'h10), level-held while the key is pressed.
REQ-008 SHALL have port key_strobe, output, 1 bit: one-cycle pulse on the cycle key changes to a non-NONE code.

Function
REQ-009 SHALL drive columns in the order 0,1,2,3,0,... with col = ~(1<<c); each column is held SCAN_DIV cycles; one frame = 4*SCAN_DIV cycles.
REQ-010 SHALL sample row on the last cycle of each column slot; a low bit r marks switch (r,c) closed.
REQ-011 SHALL use keymap row0: 1,2,3,A; row1: 4,5,6,B; row2: 7,8,9,C; row3: E,0,F,D (column 0..3 left to right).
REQ-012 SHALL form the frame result at the end of column 3: the code of the single closed switch; `KEY_NONE if zero switches or more than one switch closed (ghost rejection).
REQ-013 SHALL implement states S_IDLE, S_CONF, S_HELD, S_REL, evaluated once per frame result.
REQ-014 S_IDLE: result != NONE -> cand = result, cnt = 1, S_CONF (if DEBOUNCE = 1, go directly to the S_CONF acceptance action).
REQ-015 S_CONF: result == cand -> cnt+1; on reaching DEBOUNCE -> key = cand, key_strobe = 1 for one cycle, S_HELD; result != cand -> cnt = 0, S_IDLE.
REQ-016 S_HELD: result == key -> remain; otherwise cnt = 1, S_REL.
REQ-017 S_REL: result != key -> cnt+1; on reaching DEBOUNCE -> key = `KEY_NONE, S_IDLE; result == key -> cnt = 0, S_HELD.
REQ-018 SHALL never change key directly from one non-NONE code to another; a new key requires release to NONE first.
REQ-019 SHALL size cnt and the column timer with ceil-log2 of their parameters plus one bit; timers SHALL wrap to 0 with no lost or extra cycle.
REQ-020 Press latency SHALL be DEBOUNCE frames, measured from the first frame with the switch closed at every sample, plus at most 1 cycle.
REQ-021 Reset assertion mid-frame or mid-debounce SHALL abort immediately; scanning SHALL restart at column 0 after reset release.

Reset
REQ-022 While rst = 0: col = 4'b1110, key = `KEY_NONE, key_strobe = 0, state S_IDLE, cnt = 0, column timer = 0, cand = `KEY_NONE.
REQ-023 The first column slot after reset release SHALL last exactly SCAN_DIV cycles.

Configuration
REQ-024 SHALL honour macro KEYPAD_SYNC_EN: when defined, row passes through a 2-flop synchronizer (reset to 4'b1111) before sampling, and the sample point moves 2 cycles later within the slot and is taken from synchronized data; when undefined, row is sampled directly with no added latency.

Verification (SCAN_DIV = 4, DEBOUNCE = 3, frame = 16 cycles)
REQ-025 Hold row1 low whenever col2 is low -> after 3 frames key = 5'h06, key_strobe high exactly 1 cycle, key held.
REQ-026 Press '0' (row3/col1) for 2 frames, then release -> key stays 5'h10, key_strobe never pulses.
REQ-027 Hold 'D' (row3/col3) then release -> key = 5'h0D until 3 empty frames have elapsed, then 5'h10.
REQ-028 Close row0/col0 and row2/col1 together -> key = 5'h10 throughout, no strobe.
REQ-029 Assert rst during S_CONF with '9' pressed -> key = 5'h10, col = 4'b1110 immediately; after release, a full 3 frames are needed before key = 5'h09.
REQ-030 Build with and without KEYPAD_SYNC_EN -> identical key sequence, with strobe timing offset by exactly 2 cycles.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with ghost rejection and frame-based debounce.
// Columns are driven low one at a time. The rows are sampled at the end of each
// column slot. A debounce FSM evaluates one result per four-column frame.
// Optional build macro: KEYPAD_SYNC_EN adds a 2-flop row synchronizer. It also
// moves the sample point 2 cycles later.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 10000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key,
  output logic       key_strobe
);

  localparam int unsigned TimerW = $clog2(SCAN_DIV) + 1;
  localparam int unsigned CntW   = $clog2(DEBOUNCE) + 1;

  localparam logic [4:0]        KeyNone   = 5'h10;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [CntW-1:0]   CntDone   = CntW'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_CONF, S_HELD, S_REL} state_e;

  logic [TimerW-1:0] timer_q;
  logic [1:0]        col_idx_q;
  logic              samp_raw;

  logic [3:0] samp_row;
  logic       samp_en;
  logic [1:0] samp_col;

  logic [1:0] hits_q;
  logic [4:0] code_q;
  logic [1:0] slot_hits;
  logic [4:0] slot_code;
  logic [2:0] hits_sum;
  logic [1:0] hits_next;
  logic [4:0] code_next;
  logic       frame_done;
  logic [4:0] frame_result;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      cand_q;
  logic [4:0]      key_q;
  logic            strobe_q;

  // Map a (row, column) switch position onto its key code.
  function automatic logic [4:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    case ({r, c})
      4'b00_00: code = 5'h01;
      4'b00_01: code = 5'h02;
      4'b00_10: code = 5'h03;
      4'b00_11: code = 5'h0A;
      4'b01_00: code = 5'h04;
      4'b01_01: code = 5'h05;
      4'b01_10: code = 5'h06;
      4'b01_11: code = 5'h0B;
      4'b10_00: code = 5'h07;
      4'b10_01: code = 5'h08;
      4'b10_10: code = 5'h09;
      4'b10_11: code = 5'h0C;
      4'b11_00: code = 5'h0E;
      4'b11_01: code = 5'h00;
      4'b11_10: code = 5'h0F;
      4'b11_11: code = 5'h0D;
      default:  code = KeyNone;
    endcase
    return code;
  endfunction

  // Column slot timer: SCAN_DIV cycles per column, then advance to the next column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= '0;
      col_idx_q <= 2'd0;
    end else if (timer_q == TimerLast) begin
      timer_q   <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      timer_q <= timer_q + TimerW'(1);
    end
  end

  assign col      = ~(4'b0001 << col_idx_q);
  assign samp_raw = (timer_q == TimerLast);

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [1:0] samp_dly_q;
  logic [1:0] col_dly1_q;
  logic [1:0] col_dly2_q;

  // Synchronize the rows and delay the sample strobe and column index to match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
      samp_dly_q <= 2'b00;
      col_dly1_q <= 2'd0;
      col_dly2_q <= 2'd0;
    end else begin
      sync1_q    <= row;
      sync2_q    <= sync1_q;
      samp_dly_q <= {samp_dly_q[0], samp_raw};
      col_dly1_q <= col_idx_q;
      col_dly2_q <= col_dly1_q;
    end
  end

  assign samp_row = sync2_q;
  assign samp_en  = samp_dly_q[1];
  assign samp_col = col_dly2_q;
`else
  assign samp_row = row;
  assign samp_en  = samp_raw;
  assign samp_col = col_idx_q;
`endif

  // Count the closed switches in the current slot and merge them into the frame tally.
  always_comb begin
    slot_hits = 2'd0;
    slot_code = KeyNone;
    for (int r = 0; r < 4; r++) begin
      if (!samp_row[r]) begin
        if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
        slot_code = keymap(r[1:0], samp_col);
      end
    end
    // The tally saturates at 2: anything above one switch is a ghost/multi-press.
    hits_sum     = {1'b0, hits_q} + {1'b0, slot_hits};
    hits_next    = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_next    = (slot_hits != 2'd0) ? slot_code : code_q;
    frame_done   = samp_en && (samp_col == 2'd3);
    frame_result = (hits_next == 2'd1) ? code_next : KeyNone;
  end

  // Frame accumulator: cleared at the end of column 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q <= 2'd0;
      code_q <= KeyNone;
    end else if (samp_en) begin
      if (frame_done) begin
        hits_q <= 2'd0;
        code_q <= KeyNone;
      end else begin
        hits_q <= hits_next;
        code_q <= code_next;
      end
    end
  end

  // Debounce FSM: one evaluation per frame result, with registered key and strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= KeyNone;
      key_q    <= KeyNone;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (frame_done) begin
        unique case (state_q)
          S_IDLE: begin
            if (frame_result != KeyNone) begin
              cand_q <= frame_result;
              if (CntOne == CntDone) begin
                key_q    <= frame_result;
                strobe_q <= 1'b1;
                cnt_q    <= '0;
                state_q  <= S_HELD;
              end else begin
                cnt_q   <= CntOne;
                state_q <= S_CONF;
              end
            end
          end
          S_CONF: begin
            if (frame_result == cand_q) begin
              if (cnt_q + CntOne == CntDone) begin
                key_q    <= cand_q;
                strobe_q <= 1'b1;
                cnt_q    <= '0;
                state_q  <= S_HELD;
              end else begin
                cnt_q <= cnt_q + CntOne;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end
          S_HELD: begin
            if (frame_result != key_q) begin
              if (CntOne == CntDone) begin
                key_q   <= KeyNone;
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                cnt_q   <= CntOne;
                state_q <= S_REL;
              end
            end
          end
          S_REL: begin
            // Any other code, including a different key, counts toward release.
            if (frame_result != key_q) begin
              if (cnt_q + CntOne == CntDone) begin
                key_q   <= KeyNone;
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                cnt_q <= cnt_q + CntOne;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= S_HELD;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign key        = key_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE=3 (16-cycle frames).
// A behavioural keypad drives row from a pressed-switch mask and the live col lines.
module tb_keypad_scanner;

`ifdef KEYPAD_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [4:0]  key;
  logic        key_strobe;
  logic [15:0] pressed;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int base;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_strobe(key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switch (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) if (key_strobe) strobe_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset and release it on a falling edge; the next rising edge is P1.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    pressed = 16'h0000;
    #12;
    chk("reset_col", 16'(col), 16'h000E);
    chk("reset_key", 16'(key), 16'h0010);
    chk("reset_strobe", 16'(key_strobe), 16'h0000);

    // Column order and slot length.
    do_reset();
    chk("col_slot0", 16'(col), 16'h000E);
    step(3);
    chk("col_slot0_end", 16'(col), 16'h000E);
    step(1);
    chk("col_slot1", 16'(col), 16'h000D);
    step(8);
    chk("col_slot3", 16'(col), 16'h0007);
    step(4);
    chk("col_wrap", 16'(col), 16'h000E);
    chk("idle_key", 16'(key), 16'h0010);

    // Key '6' (row1, col2): accepted after 3 frames with a single strobe.
    pressed = 16'h0000;
    pressed[6] = 1'b1;
    do_reset();
    base = strobe_cnt;
    step(47 + Lat);
    chk("k6_before_key", 16'(key), 16'h0010);
    chk("k6_before_strobe", 16'(key_strobe), 16'h0000);
    step(1);
    chk("k6_accept_key", 16'(key), 16'h0006);
    chk("k6_accept_strobe", 16'(key_strobe), 16'h0001);
    step(1);
    chk("k6_strobe_drop", 16'(key_strobe), 16'h0000);
    chk("k6_key_held", 16'(key), 16'h0006);
    step(30);
    chk("k6_key_still", 16'(key), 16'h0006);
    chk("k6_strobe_count", 16'(strobe_cnt - base), 16'h0001);

    // Key '0' (row3, col1) held for 2 frames only: never accepted.
    pressed = 16'h0000;
    pressed[13] = 1'b1;
    do_reset();
    base = strobe_cnt;
    step(32);
    pressed = 16'h0000;
    step(17 + Lat);
    chk("k0_short_key", 16'(key), 16'h0010);
    step(31);
    chk("k0_short_key_late", 16'(key), 16'h0010);
    chk("k0_short_strobe", 16'(strobe_cnt - base), 16'h0000);

    // Key 'D' (row3, col3): held, then released after 3 empty frames.
    pressed = 16'h0000;
    pressed[15] = 1'b1;
    do_reset();
    base = strobe_cnt;
    step(48 + Lat);
    chk("kD_accept", 16'(key), 16'h000D);
    pressed = 16'h0000;
    step(47);
    chk("kD_before_release", 16'(key), 16'h000D);
    step(1);
    chk("kD_released", 16'(key), 16'h0010);
    chk("kD_strobe_count", 16'(strobe_cnt - base), 16'h0001);

    // Two switches in different columns: ghost rejection.
    pressed = 16'h0000;
    pressed[0] = 1'b1;
    pressed[9] = 1'b1;
    do_reset();
    base = strobe_cnt;
    step(48 + Lat);
    chk("ghost_key_f3", 16'(key), 16'h0010);
    step(32);
    chk("ghost_key_f5", 16'(key), 16'h0010);
    chk("ghost_strobe", 16'(strobe_cnt - base), 16'h0000);

    // Key '9' (row2, col2): reset during confirmation restarts the debounce.
    pressed = 16'h0000;
    pressed[10] = 1'b1;
    do_reset();
    base = strobe_cnt;
    step(38);
    chk("k9_pre_rst_col", 16'(col), 16'h000D);
    #2;
    rst = 1'b0;
    #1;
    chk("k9_rst_col", 16'(col), 16'h000E);
    chk("k9_rst_key", 16'(key), 16'h0010);
    chk("k9_rst_strobe", 16'(key_strobe), 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(47 + Lat);
    chk("k9_before_accept", 16'(key), 16'h0010);
    step(1);
    chk("k9_accept_key", 16'(key), 16'h0009);
    chk("k9_accept_strobe", 16'(key_strobe), 16'h0001);
    step(2);
    chk("k9_strobe_count", 16'(strobe_cnt - base), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
